// File: rtl/sobel_frame_ctrl.sv
// Frame controller around a 1-cycle Sobel window datapath: feeds active pixels,
// pads each line to LINE_LEN, and tags the result stream with window/frame markers.
module sobel_frame_ctrl #(
  parameter int unsigned LINE_LEN = 128,
  parameter int unsigned ROW_W    = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [7:0]       cfg_width,
  input  logic [ROW_W-1:0] cfg_height,
  output logic             busy,
  output logic             done,
  output logic             err_cfg,
  input  logic             s_valid,
  output logic             s_ready,
  input  logic [7:0]       s_pixel,
  output logic             sob_valid_in,
  output logic [7:0]       sob_pixel_in,
  input  logic             sob_valid_out,
  input  logic [7:0]       sob_pixel_out,
  output logic             m_valid,
  output logic [7:0]       m_pixel,
  output logic             m_win,
  output logic             m_sof,
  output logic             m_eol,
  output logic             m_eof
);

  localparam int unsigned COL_W = $clog2(LINE_LEN + 1);
  localparam logic [COL_W-1:0] LAST_COL = COL_W'(LINE_LEN - 1);

  typedef enum logic [1:0] {IDLE, RUN, PAD, DRAIN} state_t;

  state_t           state_q, state_d;
  logic [COL_W-1:0] in_col_q, in_col_d, out_col_q;
  logic [ROW_W-1:0] in_row_q, in_row_d, out_row_q;
  logic [COL_W-1:0] width_q, width_d;
  logic [ROW_W-1:0] height_q, height_d;
  logic             err_q, err_d;
  logic             clear_out;
  logic             drive;
  logic [7:0]       pix_d;
  logic             cfg_ok;
  logic             in_last_row;
  logic             out_last_row;
  logic             last_out;

  assign cfg_ok = (cfg_width >= 8'd3) && (32'(cfg_width) <= LINE_LEN) &&
                  (cfg_height >= ROW_W'(3));
  assign in_last_row  = (in_row_q == ROW_W'(height_q - ROW_W'(1)));
  assign out_last_row = (out_row_q == ROW_W'(height_q - ROW_W'(1)));
  // Final padded-or-active position of the frame leaves the datapath.
  assign last_out = (state_q == DRAIN) && sob_valid_out &&
                    (out_col_q == LAST_COL) && out_last_row;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      in_col_q <= '0;
      in_row_q <= '0;
      width_q  <= '0;
      height_q <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      in_col_q <= in_col_d;
      in_row_q <= in_row_d;
      width_q  <= width_d;
      height_q <= height_d;
      err_q    <= err_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    in_col_d  = in_col_q;
    in_row_d  = in_row_q;
    width_d   = width_q;
    height_d  = height_q;
    err_d     = 1'b0;
    clear_out = 1'b0;
    drive     = 1'b0;
    pix_d     = 8'd0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          if (cfg_ok) begin
            width_d   = COL_W'(cfg_width);
            height_d  = cfg_height;
            in_col_d  = '0;
            in_row_d  = '0;
            clear_out = 1'b1;
            state_d   = RUN;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      RUN: begin
        if (s_valid) begin
          drive = 1'b1;
          pix_d = s_pixel;
        end
      end
      PAD:     drive = 1'b1;
      DRAIN:   if (last_out) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    // Column advance; a full-length line skips PAD and wraps directly.
    if (drive) begin
      in_col_d = in_col_q + COL_W'(1);
      if (in_col_q == LAST_COL) begin
        in_col_d = '0;
        if (in_last_row) begin
          in_row_d = '0;
          state_d  = DRAIN;
        end else begin
          in_row_d = in_row_q + ROW_W'(1);
          state_d  = RUN;
        end
      end else if ((state_q == RUN) && (in_col_q == COL_W'(width_q - COL_W'(1)))) begin
        state_d = PAD;
      end
    end
  end

  // Output-side position tracks every datapath result, padded ones included.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_col_q <= '0;
      out_row_q <= '0;
    end else if (clear_out) begin
      out_col_q <= '0;
      out_row_q <= '0;
    end else if (sob_valid_out && (state_q != IDLE)) begin
      if (out_col_q == LAST_COL) begin
        out_col_q <= '0;
        out_row_q <= out_last_row ? '0 : out_row_q + ROW_W'(1);
      end else begin
        out_col_q <= out_col_q + COL_W'(1);
      end
    end
  end

  assign busy         = (state_q != IDLE);
  assign done         = last_out;
  assign err_cfg      = err_q;
  assign s_ready      = (state_q == RUN);
  assign sob_valid_in = drive;
  assign sob_pixel_in = pix_d;

  assign m_valid = sob_valid_out && (out_col_q < width_q);
  assign m_pixel = sob_pixel_out;
  assign m_win   = m_valid && (out_row_q >= ROW_W'(2)) && (out_col_q >= COL_W'(2));
  assign m_sof   = m_valid && (out_col_q == '0) && (out_row_q == '0);
  assign m_eol   = m_valid && (out_col_q == COL_W'(width_q - COL_W'(1)));
  assign m_eof   = m_eol && out_last_row;

endmodule

// File: tb/tb_sobel_frame_ctrl.sv
// Bench for sobel_frame_ctrl: raster-order expectation queue per frame plus
// per-cycle handshake checks, with a stand-in 1-cycle datapath (pixel ^ 8'hA5).
module tb_sobel_frame_ctrl;
  localparam int unsigned LINE_LEN = 128;
  localparam int unsigned ROW_W    = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  logic [7:0] cfg_width = 8'd0;
  logic [ROW_W-1:0] cfg_height = '0;
  logic busy, done, err_cfg;
  logic s_valid = 1'b0;
  logic s_ready;
  logic [7:0] s_pixel = 8'd0;
  logic sob_valid_in;
  logic [7:0] sob_pixel_in;
  logic sob_valid_out;
  logic [7:0] sob_pixel_out;
  logic m_valid, m_win, m_sof, m_eol, m_eof;
  logic [7:0] m_pixel;

  sobel_frame_ctrl #(.LINE_LEN(LINE_LEN), .ROW_W(ROW_W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .cfg_width(cfg_width),
    .cfg_height(cfg_height), .busy(busy), .done(done), .err_cfg(err_cfg),
    .s_valid(s_valid), .s_ready(s_ready), .s_pixel(s_pixel),
    .sob_valid_in(sob_valid_in), .sob_pixel_in(sob_pixel_in),
    .sob_valid_out(sob_valid_out), .sob_pixel_out(sob_pixel_out),
    .m_valid(m_valid), .m_pixel(m_pixel), .m_win(m_win), .m_sof(m_sof),
    .m_eol(m_eol), .m_eof(m_eof)
  );

  always #5 clk = ~clk;

  // Stand-in Sobel datapath: fixed 1-cycle latency, recognisable transform.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sob_valid_out <= 1'b0;
      sob_pixel_out <= 8'd0;
    end else begin
      sob_valid_out <= sob_valid_in;
      sob_pixel_out <= sob_pixel_in ^ 8'hA5;
    end
  end

  typedef struct packed {
    logic [7:0] pix;
    logic win, sof, eol, eof;
  } exp_t;

  exp_t exp_q[$];
  int n_tests = 0;
  int n_fail  = 0;
  int cyc = 0;
  int done_cnt = 0, done_cyc = 0, last_drive_cyc = 0;
  int valid_cnt = 0, win_cnt = 0, sof_cnt = 0, eol_cnt = 0, eof_cnt = 0;
  int pad_cnt = 0, xfer_cnt = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] px(input int r, input int c);
    return 8'(r * 37 + c * 11 + 3);
  endfunction

  // Compare process: every cycle, sampled on the falling edge.
  always @(negedge clk) begin
    exp_t e;
    cyc++;
    if (m_valid) begin
      valid_cnt++;
      if (m_win) win_cnt++;
      if (m_sof) sof_cnt++;
      if (m_eol) eol_cnt++;
      if (m_eof) eof_cnt++;
      if (exp_q.size() == 0) begin
        check("extra_m_valid", 32'(1), 32'(0));
      end else begin
        e = exp_q.pop_front();
        check("m_pixel", 32'(m_pixel), 32'(e.pix));
        check("m_flags", 32'({m_win, m_sof, m_eol, m_eof}),
              32'({e.win, e.sof, e.eol, e.eof}));
      end
    end else begin
      check("flags_no_valid", 32'({m_win, m_sof, m_eol, m_eof}), 32'(0));
    end
    if (done) begin
      done_cnt++;
      done_cyc = cyc;
    end
    if (sob_valid_in) last_drive_cyc = cyc;
    if (!busy) check("idle_sob_valid_in", 32'(sob_valid_in), 32'(0));
    if (s_ready && s_valid) begin
      xfer_cnt++;
      check("xfer_drive", 32'({sob_valid_in, sob_pixel_in}), 32'({1'b1, s_pixel}));
    end else if (s_ready) begin
      check("no_xfer_drive", 32'(sob_valid_in), 32'(0));
    end else if (sob_valid_in) begin
      pad_cnt++;
      check("pad_pixel", 32'(sob_pixel_in), 32'(0));
    end
  end

  task automatic run_frame(input int w, input int h, input bit toggle,
                           input int ev, input int ew, input int ep,
                           input bit mid_start, input int abort_at);
    exp_t e;
    int t, idx;
    bit consumed;
    int b_done, b_valid, b_win, b_sof, b_eol, b_eof, b_pad, b_xfer;
    exp_q.delete();
    for (int r = 0; r < h; r++) begin
      for (int c = 0; c < w; c++) begin
        e.pix = px(r, c) ^ 8'hA5;
        e.win = (r >= 2) && (c >= 2);
        e.sof = (r == 0) && (c == 0);
        e.eol = (c == w - 1);
        e.eof = (c == w - 1) && (r == h - 1);
        exp_q.push_back(e);
      end
    end
    check("model_size", 32'(exp_q.size()), 32'(ev));
    b_done = done_cnt; b_valid = valid_cnt; b_win = win_cnt; b_sof = sof_cnt;
    b_eol = eol_cnt; b_eof = eof_cnt; b_pad = pad_cnt; b_xfer = xfer_cnt;
    cfg_width = 8'(w);
    cfg_height = ROW_W'(h);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check("busy_after_start", 32'(busy), 32'(1));
    check("no_err_legal", 32'(err_cfg), 32'(0));
    t = 0;
    idx = 0;
    while (done_cnt == b_done && t < 3000) begin
      s_valid = (idx < w * h) && (!toggle || (t % 2 == 0));
      s_pixel = px(idx / w, idx % w);
      if (mid_start && t == 2) begin
        start = 1'b1;
        cfg_width = 8'd3;
        cfg_height = ROW_W'(3);
      end
      if (abort_at > 0 && t == abort_at) begin
        rst_n = 1'b0;
        #1;
        check("abort_busy", 32'(busy), 32'(0));
        check("abort_s_ready", 32'(s_ready), 32'(0));
        s_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        check("abort_no_done", 32'(done_cnt - b_done), 32'(0));
        exp_q.delete();
        return;
      end
      @(negedge clk);
      consumed = s_valid && s_ready;
      @(posedge clk); #1;
      start = 1'b0;
      if (consumed) idx++;
      t++;
    end
    s_valid = 1'b0;
    check("frame_done", 32'(done_cnt - b_done), 32'(1));
    check("busy_after_done", 32'(busy), 32'(0));
    check("done_latency", 32'(done_cyc - last_drive_cyc), 32'(1));
    check("xfer_count", 32'(xfer_cnt - b_xfer), 32'(w * h));
    check("m_valid_count", 32'(valid_cnt - b_valid), 32'(ev));
    check("m_win_count", 32'(win_cnt - b_win), 32'(ew));
    check("pad_count", 32'(pad_cnt - b_pad), 32'(ep));
    check("sof_count", 32'(sof_cnt - b_sof), 32'(1));
    check("eol_count", 32'(eol_cnt - b_eol), 32'(h));
    check("eof_count", 32'(eof_cnt - b_eof), 32'(1));
    check("queue_drained", 32'(exp_q.size()), 32'(0));
  endtask

  task automatic bad_start(input int w, input int h);
    cfg_width = 8'(w);
    cfg_height = ROW_W'(h);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check("err_pulse", 32'(err_cfg), 32'(1));
    check("err_busy", 32'(busy), 32'(0));
    @(posedge clk); #1;
    check("err_one_cycle", 32'(err_cfg), 32'(0));
    check("err_still_idle", 32'(busy), 32'(0));
  endtask

  initial begin
    #3;
    check("rst_outputs", 32'({busy, done, err_cfg, s_ready, sob_valid_in, m_valid}), 32'(0));
    check("rst_sob_pixel_in", 32'(sob_pixel_in), 32'(0));
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;

    run_frame(128, 3, 1'b0, 384, 126, 0, 1'b0, 0);
    run_frame(4, 3, 1'b0, 12, 2, 3 * 124, 1'b1, 0);
    run_frame(5, 4, 1'b1, 20, 6, 4 * 123, 1'b0, 0);
    bad_start(2, 3);
    bad_start(5, 0);
    run_frame(5, 3, 1'b0, 15, 3, 3 * 123, 1'b0, 130);
    run_frame(3, 3, 1'b0, 9, 1, 3 * 125, 1'b0, 0);

    repeat (3) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
